// File: rtl/uart_btn_cmd_decoder_if.sv
// uart_btn_cmd_decoder_if
//   Byte stream from the UART receiver into the command decoder.
//   rx_data  8  received byte, meaningful only while rx_done is high
//   rx_done  1  one-cycle strobe marking a new byte on rx_data
//   modport master: the UART receiver (drives the byte stream)
//   modport slave : the command decoder (consumes the byte stream)
interface uart_btn_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;

  modport master (output rx_data, output rx_done);
  modport slave  (input  rx_data, input  rx_done);
endinterface

// File: rtl/uart_btn_cmd_decoder.sv
// uart_btn_cmd_decoder
//   Turns ASCII command bytes from the UART receiver into timed button
//   presses, one 4-bit press vector per mode (watch, stopwatch, sr04, dht11).
//   A bare letter U/D/L/R (any case) presses in the mode chosen by sw_sel;
//   '#'<0-3><letter> presses in the explicitly addressed mode.
//
// Ports
//   clk                   in   system clock, rising edge
//   reset                 in   synchronous active-high reset
//   rx                    if   byte stream (rx_data / rx_done), slave side
//   sw_sel                in   current mode (0 watch, 1 stopwatch, 2 sr04, 3 dht11)
//   o_btn_uart_watch      out  press vector, watch mode
//   o_btn_uart_stopwatch  out  press vector, stopwatch mode
//   o_btn_uart_sr04       out  press vector, sr04 mode
//   o_btn_uart_dht11      out  press vector, dht11 mode
//   o_cmd_err             out  one-cycle pulse when a byte is rejected or a
//                              '#' sequence times out
//   tx_busy / tx_start / tx_data  (only with ECHO_EN) upper-case echo of
//                              every accepted letter to the UART transmitter
//
// Build option: define ECHO_EN to add the echo path and its tx ports.
module uart_btn_cmd_decoder #(
  parameter int PULSE_CYCLES   = 100_000,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  uart_btn_cmd_decoder_if.slave   rx,
  input  logic [1:0]              sw_sel,
  output logic [3:0]              o_btn_uart_watch,
  output logic [3:0]              o_btn_uart_stopwatch,
  output logic [3:0]              o_btn_uart_sr04,
  output logic [3:0]              o_btn_uart_dht11,
  output logic                    o_cmd_err
`ifdef ECHO_EN
  ,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_data
`endif
);

  localparam int PW = (PULSE_CYCLES   > 1) ? $clog2(PULSE_CYCLES)   : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PFX   = 2'd1,
    S_TGT   = 2'd2,
    S_PRESS = 2'd3
  } state_t;

  state_t        state_reg,  state_next;
  logic [1:0]    target_reg, target_next;
  logic [3:0]    bit_reg,    bit_next;
  logic [PW-1:0] pulse_reg,  pulse_next;
  logic [TW-1:0] to_reg,     to_next;
  logic          err_reg,    err_next;
  logic          accept_letter;
  logic [3:0]    letter_bit;

  // One-hot button bit for U/D/L/R in either case, zero for anything else.
  always_comb begin
    letter_bit = 4'b0000;
    case (rx.rx_data)
      8'h55, 8'h75: letter_bit = 4'b0001;  // U u
      8'h44, 8'h64: letter_bit = 4'b0010;  // D d
      8'h4C, 8'h6C: letter_bit = 4'b0100;  // L l
      8'h52, 8'h72: letter_bit = 4'b1000;  // R r
      default:      letter_bit = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      target_reg <= 2'b00;
      bit_reg    <= 4'b0000;
      pulse_reg  <= '0;
      to_reg     <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      bit_reg    <= bit_next;
      pulse_reg  <= pulse_next;
      to_reg     <= to_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    target_next   = target_reg;
    bit_next      = bit_reg;
    pulse_next    = pulse_reg;
    to_next       = to_reg;
    err_next      = 1'b0;
    accept_letter = 1'b0;

    case (state_reg)
      S_IDLE: begin
        to_next = '0;
        if (rx.rx_done) begin
          if (letter_bit != 4'b0000) begin
            target_next   = sw_sel;
            bit_next      = letter_bit;
            pulse_next    = PULSE_LAST;
            accept_letter = 1'b1;
            state_next    = S_PRESS;
          end else if (rx.rx_data == 8'h23) begin
            state_next = S_PFX;
          end else if (rx.rx_data != 8'h0D && rx.rx_data != 8'h0A) begin
            err_next = 1'b1;
          end
        end
      end

      S_PFX: begin
        if (rx.rx_done) begin
          // '0'..'3' are 8'h30..8'h33: upper six bits fixed, low two are the mode.
          if (rx.rx_data[7:2] == 6'b001100) begin
            target_next = rx.rx_data[1:0];
            to_next     = '0;
            state_next  = S_TGT;
          end else begin
            err_next   = 1'b1;
            state_next = S_IDLE;
          end
        end else if (to_reg == TIMEOUT_LAST) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          to_next = to_reg + 1'b1;
        end
      end

      S_TGT: begin
        if (rx.rx_done) begin
          if (letter_bit != 4'b0000) begin
            bit_next      = letter_bit;
            pulse_next    = PULSE_LAST;
            accept_letter = 1'b1;
            state_next    = S_PRESS;
          end else begin
            err_next   = 1'b1;
            state_next = S_IDLE;
          end
        end else if (to_reg == TIMEOUT_LAST) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          to_next = to_reg + 1'b1;
        end
      end

      S_PRESS: begin
        // Bytes arriving mid-press are dropped; the press keeps running.
        if (rx.rx_done) begin
          err_next = 1'b1;
        end
        if (pulse_reg == '0) begin
          state_next = S_IDLE;
        end else begin
          pulse_next = pulse_reg - 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // The press is visible only while in PRESS, so leaving PRESS (or reset)
  // drops the vector in the same cycle the state changes.
  logic [3:0] btn_mode [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      assign btn_mode[gi] = (state_reg == S_PRESS && target_reg == 2'(gi)) ? bit_reg : 4'b0000;
    end
  endgenerate

  assign o_btn_uart_watch     = btn_mode[0];
  assign o_btn_uart_stopwatch = btn_mode[1];
  assign o_btn_uart_sr04      = btn_mode[2];
  assign o_btn_uart_dht11     = btn_mode[3];
  assign o_cmd_err            = err_reg;

`ifdef ECHO_EN
  logic       echo_full_reg;
  logic [7:0] echo_data_reg;
  logic       tx_start_reg;
  logic [7:0] tx_data_reg;

  // One-deep holding register in front of the transmitter. A letter that
  // arrives while it is still occupied is silently discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_full_reg <= 1'b0;
      echo_data_reg <= 8'h00;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= 8'h00;
    end else begin
      tx_start_reg <= 1'b0;
      if (echo_full_reg && !tx_busy) begin
        tx_start_reg  <= 1'b1;
        tx_data_reg   <= echo_data_reg;
        echo_full_reg <= 1'b0;
      end
      if (accept_letter && !echo_full_reg) begin
        echo_full_reg <= 1'b1;
        echo_data_reg <= rx.rx_data & 8'hDF;  // clearing bit 5 upper-cases a letter
      end
    end
  end

  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;
`endif

endmodule
